// File: rtl/nl_vc_inject_scheduler.sv
// nl_vc_inject_scheduler: shares one router injection port between nr source FIFOs.
//   Binds each packet to a free entry VC on its head flit and keeps that binding until the tail.
//   Picks at most one flit per cycle, round-robin across requesters. Grant is combinational (same-cycle pop).
// Ports:
//   req_valid/req_head/req_tail : per-requester flit at FIFO head
//   net_full/net_empty          : per-VC router buffer status
//   grant/out_valid/out_vc/out_src : pop, valid, one-hot VC stamp, mux select
//   pkt_count/proto_err         : wrapping tail counter, sticky protocol-violation flag
module nl_vc_inject_scheduler #(
  parameter int nr    = 4,
  parameter int nv    = 4,
  parameter int cnt_w = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [nr-1:0]         req_valid,
  input  logic [nr-1:0]         req_head,
  input  logic [nr-1:0]         req_tail,
  input  logic [nv-1:0]         net_full,
  input  logic [nv-1:0]         net_empty,
  output logic [nr-1:0]         grant,
  output logic                  out_valid,
  output logic [nv-1:0]         out_vc,
  output logic [$clog2(nr)-1:0] out_src,
  output logic [cnt_w-1:0]      pkt_count,
  output logic                  proto_err
);
  localparam int sw = $clog2(nr);
  localparam int vw = (nv > 1) ? $clog2(nv) : 1;

  // Cyclic offset helpers used by both pointer searches and pointer updates.
  function automatic logic [vw-1:0] vc_at(logic [vw-1:0] base, int k);
    return vw'((int'(base) + k) % nv);
  endfunction

  function automatic logic [sw-1:0] req_at(logic [sw-1:0] base, int k);
    return sw'((int'(base) + k) % nr);
  endfunction

  // State: vc_busy_q is the per-VC FREE(0)/BOUND(1) state.
  logic [nv-1:0]    vc_busy_q, vc_busy_d;
  logic [nr-1:0]    bound_q, bound_d;
  logic [vw-1:0]    bound_vc_q [nr];
  logic [vw-1:0]    bound_vc_d [nr];
  logic [sw-1:0]    rr_ptr_q, rr_ptr_d;
  logic [vw-1:0]    vc_ptr_q, vc_ptr_d;
  logic [cnt_w-1:0] pkt_count_d;
  logic             proto_err_d;

  logic             free_found;
  logic [vw-1:0]    free_vc;
  logic [nr-1:0]    elig;
  logic [nr-1:0]    viol;
  logic             win_found;
  logic [sw-1:0]    win;

  // Eligibility and arbitration. Only one head can win per cycle, so a single
  // free-VC candidate is enough.
  always_comb begin
    free_found = 1'b0;
    free_vc    = '0;
    for (int k = 0; k < nv; k++) begin
      if (!free_found && !vc_busy_q[vc_at(vc_ptr_q, k)] &&
          net_empty[vc_at(vc_ptr_q, k)] && !net_full[vc_at(vc_ptr_q, k)]) begin
        free_found = 1'b1;
        free_vc    = vc_at(vc_ptr_q, k);
      end
    end

    elig = '0;
    viol = '0;
    for (int i = 0; i < nr; i++) begin
      if (bound_q[i]) begin
        elig[i] = req_valid[i] & ~req_head[i] & ~net_full[bound_vc_q[i]];
        viol[i] = req_valid[i] & req_head[i];
      end else begin
        elig[i] = req_valid[i] & req_head[i] & free_found;
        viol[i] = req_valid[i] & ~req_head[i];
      end
    end

    // rst_n gates the grant so nothing pops while the block is held in reset.
    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < nr; k++) begin
      if (rst_n && !win_found && elig[req_at(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win       = req_at(rr_ptr_q, k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_busy_q <= '0;
      bound_q   <= '0;
      for (int i = 0; i < nr; i++) bound_vc_q[i] <= '0;
      rr_ptr_q  <= '0;
      vc_ptr_q  <= '0;
      pkt_count <= '0;
      proto_err <= 1'b0;
    end else begin
      vc_busy_q  <= vc_busy_d;
      bound_q    <= bound_d;
      bound_vc_q <= bound_vc_d;
      rr_ptr_q   <= rr_ptr_d;
      vc_ptr_q   <= vc_ptr_d;
      pkt_count  <= pkt_count_d;
      proto_err  <= proto_err_d;
    end
  end

  // Next state. A granted head&tail flit never binds, so its VC stays FREE.
  always_comb begin
    vc_busy_d   = vc_busy_q;
    bound_d     = bound_q;
    bound_vc_d  = bound_vc_q;
    rr_ptr_d    = rr_ptr_q;
    vc_ptr_d    = vc_ptr_q;
    pkt_count_d = pkt_count;
    proto_err_d = proto_err | (|viol);
    if (win_found) begin
      rr_ptr_d = req_at(win, 1);
      if (!bound_q[win]) begin
        vc_ptr_d = vc_at(free_vc, 1);
        if (!req_tail[win]) begin
          bound_d[win]       = 1'b1;
          bound_vc_d[win]    = free_vc;
          vc_busy_d[free_vc] = 1'b1;
        end
      end else if (req_tail[win]) begin
        bound_d[win]                = 1'b0;
        vc_busy_d[bound_vc_q[win]] = 1'b0;
      end
      if (req_tail[win]) pkt_count_d = pkt_count + 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    grant     = '0;
    out_valid = 1'b0;
    out_vc    = '0;
    out_src   = '0;
    if (win_found) begin
      grant[win] = 1'b1;
      out_valid  = 1'b1;
      out_src    = win;
      if (bound_q[win]) out_vc[bound_vc_q[win]] = 1'b1;
      else              out_vc[free_vc]         = 1'b1;
    end
  end

  // Router status must be known whenever a source is requesting.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (|req_valid) |-> !$isunknown({net_full, net_empty}));

endmodule

// File: tb/tb_nl_vc_inject_scheduler.sv
module tb_nl_vc_inject_scheduler;
  localparam int NR = 4;
  localparam int NV = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NR-1:0] req_valid, req_head, req_tail, grant;
  logic [NV-1:0] net_full, net_empty, out_vc;
  logic          out_valid;
  logic [1:0]    out_src;
  logic [CW-1:0] pkt_count;
  logic          proto_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nl_vc_inject_scheduler #(.nr(NR), .nv(NV), .cnt_w(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail),
    .net_full(net_full), .net_empty(net_empty),
    .grant(grant), .out_valid(out_valid), .out_vc(out_vc), .out_src(out_src),
    .pkt_count(pkt_count), .proto_err(proto_err)
  );

  // Reference model: which VC each requester holds (-1 = none), pointers, counters.
  int            m_hold[NR];
  int            m_rr, m_vp;
  logic [CW-1:0] m_cnt;
  bit            m_perr;
  int            m_win, m_ff;
  bit            m_viol;

  // Traffic sources.
  int s_len[NR];
  int s_pos[NR];
  bit s_act[NR];
  int vprob;
  bit refill, net_rand;

  logic [NR-1:0] obs_grant;
  logic [NV-1:0] obs_vc;
  logic [1:0]    obs_src;

  function automatic bit rbit(logic [NR-1:0] v, int i);
    return |(v & (NR'(1) << i));
  endfunction
  function automatic bit vbit(logic [NV-1:0] v, int i);
    return |(v & (NV'(1) << i));
  endfunction
  function automatic logic [NR-1:0] rone(int i);
    return NR'(1) << i;
  endfunction
  function automatic logic [NV-1:0] vone(int i);
    return NV'(1) << i;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit vc_taken(int v);
    for (int i = 0; i < NR; i++) if (m_hold[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_hold[i] = -1;
    m_rr = 0; m_vp = 0; m_cnt = '0; m_perr = 0;
  endfunction

  // Choose the candidate nearest (cyclically) at or after the pointer.
  function automatic void model_eval();
    int best;
    int q[$];
    m_ff = -1; best = NV;
    for (int v = 0; v < NV; v++)
      if (!vc_taken(v) && vbit(net_empty, v) && !vbit(net_full, v)) q.push_back(v);
    foreach (q[j]) if ((q[j] - m_vp + NV) % NV < best) begin best = (q[j] - m_vp + NV) % NV; m_ff = q[j]; end
    q.delete();
    m_viol = 0;
    for (int i = 0; i < NR; i++) begin
      bit v, h;
      v = rbit(req_valid, i); h = rbit(req_head, i);
      if (m_hold[i] >= 0) begin
        if (v && h) m_viol = 1;
        if (v && !h && !vbit(net_full, m_hold[i])) q.push_back(i);
      end else begin
        if (v && !h) m_viol = 1;
        if (v && h && m_ff >= 0) q.push_back(i);
      end
    end
    m_win = -1; best = NR;
    foreach (q[j]) if ((q[j] - m_rr + NR) % NR < best) begin best = (q[j] - m_rr + NR) % NR; m_win = q[j]; end
  endfunction

  function automatic void model_commit();
    bit t;
    if (m_viol) m_perr = 1;
    if (m_win < 0) return;
    t = rbit(req_tail, m_win);
    m_rr = (m_win + 1) % NR;
    if (t) m_cnt = m_cnt + 1;
    if (m_hold[m_win] < 0) begin
      m_vp = (m_ff + 1) % NV;
      if (!t) m_hold[m_win] = m_ff;
    end else if (t) m_hold[m_win] = -1;
  endfunction

  // One clock: compare at negedge, then commit model on the edge.
  task automatic step();
    logic [NR-1:0] eg;
    logic [NV-1:0] ev;
    @(negedge clk);
    model_eval();
    eg = '0; ev = '0;
    if (m_win >= 0) begin
      eg = rone(m_win);
      ev = vone((m_hold[m_win] >= 0) ? m_hold[m_win] : m_ff);
    end
    obs_grant = grant; obs_vc = out_vc; obs_src = out_src;
    chk("grant", 32'(grant), 32'(eg));
    chk("out_valid", 32'(out_valid), 32'(m_win >= 0));
    chk("out_vc", 32'(out_vc), 32'(ev));
    chk("out_src", 32'(out_src), 32'((m_win >= 0) ? m_win : 0));
    chk("pkt_count", pkt_count, m_cnt);
    chk("proto_err", 32'(proto_err), 32'(m_perr));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic start_src(int i, int len);
    s_act[i] = 1; s_len[i] = len; s_pos[i] = 0;
  endtask

  task automatic cycle();
    logic [NR-1:0] rv, rh, rt;
    rv = '0; rh = '0; rt = '0;
    for (int i = 0; i < NR; i++) begin
      if (s_act[i] && ($urandom_range(99) < vprob)) rv |= rone(i);
      if (s_pos[i] == 0) rh |= rone(i);
      if (s_pos[i] == s_len[i] - 1) rt |= rone(i);
    end
    req_valid = rv; req_head = rh; req_tail = rt;
    if (net_rand) begin
      for (int v = 0; v < NV; v++) begin
        net_full  = (net_full & ~vone(v)) | (($urandom_range(9) == 0) ? vone(v) : '0);
        net_empty = (net_empty & ~vone(v)) | (($urandom_range(9) != 0) ? vone(v) : '0);
      end
    end
    step();
    if (m_win >= 0) begin
      s_pos[m_win]++;
      if (s_pos[m_win] == s_len[m_win]) begin
        s_pos[m_win] = 0;
        if (refill) s_len[m_win] = $urandom_range(1, 4);
        else s_act[m_win] = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; req_head = '0; req_tail = '0; net_full = '0; net_empty = '1;
    model_reset();
    for (int i = 0; i < NR; i++) begin s_act[i] = 0; s_pos[i] = 0; s_len[i] = 1; end
    vprob = 100; refill = 0; net_rand = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    // Reset state: outputs low even with heads presented.
    req_valid = '1; req_head = '1; req_tail = '0; net_full = '0; net_empty = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_vc", 32'(out_vc), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_pkt_count", pkt_count, 32'h0);
    chk("rst_proto_err", 32'(proto_err), 32'h0);
    do_reset();

    // Single source, four 3-flit packets: VC rotates 0..3.
    for (int p = 0; p < 4; p++) begin
      start_src(0, 3);
      for (int f = 0; f < 3; f++) begin
        cycle();
        chk("t2_vc", 32'(obs_vc), 32'(vone(p)));
      end
    end
    chk("t2_pkt_count", pkt_count, 32'd4);

    // Randomized traffic, then asynchronous reset mid-packet.
    do_reset();
    vprob = 80; refill = 1; net_rand = 1;
    for (int i = 0; i < NR; i++) start_src(i, $urandom_range(1, 4));
    for (int c = 0; c < 400; c++) cycle();
    chk("rand_progress", 32'(pkt_count != 0), 32'h1);
    req_valid = '1; req_head = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_pkt_count", pkt_count, 32'h0);
    chk("mid_rst_proto_err", 32'(proto_err), 32'h0);
    do_reset();

    // Four simultaneous heads: distinct VCs, then strict round-robin.
    for (int i = 0; i < NR; i++) start_src(i, 3);
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k < 4) begin
        chk("t3_head_grant", 32'(obs_grant), 32'(rone(k)));
        chk("t3_head_vc", 32'(obs_vc), 32'(vone(k)));
      end else chk("t3_body_src", 32'(obs_src), 32'(k % 4));
    end
    chk("t3_pkt_count", pkt_count, 32'd4);

    // Backpressure on requester 1's VC stalls only requester 1.
    do_reset();
    for (int i = 0; i < NR; i++) start_src(i, 20);
    for (int k = 0; k < 4; k++) cycle();
    net_full = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_stall", 32'(rbit(obs_grant, 1)), 32'h0);
      chk("t4_others", 32'(obs_grant != 0), 32'h1);
    end
    net_full = '0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      seen |= rbit(obs_grant, 1);
    end
    chk("t4_resume", 32'(seen), 32'h1);

    // Head waits for a released VC that is also empty.
    do_reset();
    net_empty = 4'b0001;
    start_src(0, 3); start_src(1, 2);
    cycle();
    chk("t5_bind", 32'(obs_grant), 32'h1);
    net_empty = 4'b0000;
    cycle(); cycle();
    cycle();
    chk("t5_wait", 32'(obs_grant), 32'h0);
    net_empty = 4'b0001;
    cycle();
    chk("t5_grant", 32'(obs_grant), 32'h2);
    chk("t5_vc", 32'(obs_vc), 32'h1);

    // Protocol error, then single-flit packets that never bind a VC.
    do_reset();
    req_valid = 4'b0001; req_head = '0; req_tail = '0;
    step();
    chk("t6_no_grant", 32'(obs_grant), 32'h0);
    req_valid = '0;
    step();
    chk("t6_perr", 32'(proto_err), 32'h1);
    req_valid = 4'b0100; req_head = 4'b0100; req_tail = 4'b0100;
    step();
    chk("t6_ht_grant", 32'(obs_grant), 32'h4);
    chk("t6_ht_count", pkt_count, 32'd1);
    net_empty = 4'b0001;
    step();
    chk("t6_vc_free", 32'(obs_vc), 32'h1);
    chk("t6_ht_count2", pkt_count, 32'd2);
    chk("t6_perr_sticky", 32'(proto_err), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
